// File: rtl/sram_bridge.sv
// AVR-to-SRAM bridge: synchronised AVR strobes drive a timed SRAM access FSM with explicit tristate control.
// Optional diagnostics on the debug bus are built only when SRAM_BRIDGE_DEBUG_EN is defined.
module sram_bridge #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avr_we_n,
  input  logic              avr_oe_n,
  input  logic [AWIDTH-1:0] avr_addr,
  inout  wire  [DWIDTH-1:0] avr_data,
  output logic [AWIDTH-1:0] sram_addr,
  inout  wire  [DWIDTH-1:0] sram_data,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              collision,
  output logic [7:0]        debug
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_SETUP = 4'd1,
    WR_PULSE = 4'd2,
    WR_HOLD  = 4'd3,
    WR_DONE  = 4'd4,
    RD_SETUP = 4'd5,
    RD_WAIT  = 4'd6,
    RD_DRIVE = 4'd7,
    TURN     = 4'd8
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t              state_q;
  logic [SYNC_STAGES-1:0] we_sync_q, oe_sync_q;
  logic                we_s, oe_s;
  logic [3:0]          cnt_q;
  logic [DWIDTH-1:0]   wr_q, rd_q;
  logic [AWIDTH-1:0]   addr_q;
  logic                we_n_q, oe_n_q, sram_drv_q, avr_drv_q, busy_q, coll_q;

  // Raw pins only ever feed the first synchroniser flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_sync_q <= '1;
      oe_sync_q <= '1;
    end else begin
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], avr_we_n};
      oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], avr_oe_n};
    end
  end

  assign we_s = we_sync_q[SYNC_STAGES-1];
  assign oe_s = oe_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      sram_drv_q <= 1'b0;
      avr_drv_q  <= 1'b0;
      busy_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      coll_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write has priority when both strobes arrive together.
          if (!we_s) begin
            state_q    <= WR_SETUP;
            addr_q     <= avr_addr;
            wr_q       <= avr_data;
            sram_drv_q <= 1'b1;
            busy_q     <= 1'b1;
            coll_q     <= !oe_s;
          end else if (!oe_s) begin
            state_q <= RD_SETUP;
            addr_q  <= avr_addr;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        WR_SETUP: begin
          state_q <= WR_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= WAIT_LD;
        end
        WR_PULSE: begin
          if (cnt_q == 4'd0) begin
            state_q <= WR_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_HOLD: begin
          state_q    <= WR_DONE;
          sram_drv_q <= 1'b0;
        end
        WR_DONE: begin
          if (we_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RD_SETUP: begin
          state_q <= RD_WAIT;
          cnt_q   <= WAIT_LD;
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= RD_DRIVE;
            rd_q      <= sram_data;
            oe_n_q    <= 1'b1;
            avr_drv_q <= !oe_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_DRIVE: begin
          if (oe_s) begin
            state_q   <= TURN;
            avr_drv_q <= 1'b0;
          end else begin
            avr_drv_q <= 1'b1;
          end
        end
        TURN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          we_n_q     <= 1'b1;
          oe_n_q     <= 1'b1;
          sram_drv_q <= 1'b0;
          avr_drv_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign busy      = busy_q;
  assign collision = coll_q;
  assign sram_data = sram_drv_q ? wr_q : 'z;
  assign avr_data  = avr_drv_q  ? rd_q : 'z;

`ifdef SRAM_BRIDGE_DEBUG_EN
  logic [1:0] coll_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_cnt_q <= 2'd0;
    end else if ((state_q == IDLE) && !we_s && !oe_s && (coll_cnt_q != 2'd3)) begin
      coll_cnt_q <= coll_cnt_q + 2'd1;
    end
  end

  assign debug = {coll_cnt_q, oe_s, we_s, state_q};
`else
  assign debug = 8'd0;
`endif

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Parametrised AVR-to-SRAM bus bridge in the CPLD; next generation of the AVR/SRAM data-path FSM.
- Synchronises the AVR's asynchronous active-low strobes and latches the address as well as the data.
- Generates timed SRAM write/read strobes with programmable wait states; reads are captured into a holding register.
- Tristate enables are explicit, with a turnaround cycle, so no two bus drivers ever overlap.

Parameters:
- DWIDTH, 8, data bus width (both sides)
- AWIDTH, 16, address width (both sides)
- WAIT_CYCLES, 1, extra SRAM strobe cycles beyond the first (0..15)
- SYNC_STAGES, 2, synchroniser depth for avr_we_n/avr_oe_n (min 2)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- avr_we_n  input  1  AVR write strobe, active-low, asynchronous to clk
- avr_oe_n  input  1  AVR read strobe, active-low, asynchronous to clk
- avr_addr  input  AWIDTH  AVR address
- avr_data  inout  DWIDTH  AVR data bus
- sram_addr  output  AWIDTH  registered SRAM address
- sram_data  inout  DWIDTH  SRAM data bus
- sram_we_n  output  1  SRAM write enable, active-low
- sram_oe_n  output  1  SRAM output enable, active-low
- busy  output  1  high whenever state != IDLE
- collision  output  1  one-cycle pulse when both strobes are seen low in the same IDLE cycle
- debug  output  8  diagnostic bus; see Optional Feature

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, sram_we_n=1, sram_oe_n=1, sram_addr=0
  - avr_data=Z, sram_data=Z, busy=0, collision=0, debug=0
  - synchroniser flops=1, wait counter=0, data registers=0
- Reset mid-transaction aborts at once; both buses are released in the same instant.
- Strobes pass through SYNC_STAGES flops; only the synchronised values we_s/oe_s are used. The raw pins never drive logic directly.
- Wait counter: 4 bits, loaded with WAIT_CYCLES, decremented to 0.
- States and transitions:
  - IDLE:
    - we_s=0 -> WR_SETUP, latching avr_addr->sram_addr and avr_data->wr_reg.
    - else oe_s=0 -> RD_SETUP, latching avr_addr->sram_addr.
    - we_s=0 and oe_s=0 together -> write wins and collision pulses 1 cycle.
  - WR_SETUP (1 cycle): drive sram_data=wr_reg, sram_we_n=1 -> WR_PULSE; counter loaded.
  - WR_PULSE (WAIT_CYCLES+1 cycles): sram_we_n=0, data still driven -> WR_HOLD when counter=0.
  - WR_HOLD (1 cycle): sram_we_n=1, data still driven -> WR_DONE.
  - WR_DONE: sram_data=Z; stay until we_s=1 -> IDLE. One strobe produces exactly one write.
  - RD_SETUP (1 cycle): sram_oe_n=0 -> RD_WAIT; counter loaded.
  - RD_WAIT (WAIT_CYCLES+1 cycles): sram_oe_n=0; on the cycle counter=0, capture sram_data->rd_reg -> RD_DRIVE.
  - RD_DRIVE: sram_oe_n=1; avr_data driven with rd_reg while oe_s=0; oe_s=1 -> TURN.
  - TURN (1 cycle): avr_data=Z, everything released -> IDLE.
- Bus ownership rules:
  - sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD.
  - avr_data is driven only in RD_DRIVE.
  - sram_oe_n=0 and a driven sram_data are never true in the same cycle.
- Latency, counted from a synchronised strobe low seen in IDLE:
  - Write: sram_we_n falls 2 cycles later and stays low WAIT_CYCLES+1 cycles.
  - Read: rd_reg is valid after WAIT_CYCLES+2 cycles; avr_data is driven from the following cycle.
- A strobe deasserting early does not abort the sequence:
  - Write: the write completes.
  - Read: RD_DRIVE sees oe_s=1 and goes straight to TURN without driving.
- The other strobe is ignored while busy=1.

Optional Feature:
- Macro: SRAM_BRIDGE_DEBUG_EN.
- Defined:
  - debug[3:0] = state encoding.
  - debug[4] = we_s, debug[5] = oe_s.
  - debug[7:6] = saturating 2-bit collision counter, cleared only by reset.
- Undefined: debug is constant 0, and the counter and its logic are not built.

Test Plan:
- Write, WAIT_CYCLES=1: avr_addr=0x1234, avr_data=0xA5, avr_we_n low 10 cycles -> sram_addr=0x1234, sram_data=0xA5, sram_we_n low exactly 2 cycles; one write only; sram_data=Z after WR_HOLD; busy=0 after we_n high + sync.
- Read, WAIT_CYCLES=1: SRAM model returns 0x3C at 0x00FF, avr_oe_n low -> sram_oe_n low 3 cycles; avr_data=0x3C while avr_oe_n low; avr_data=Z one cycle after oe_s rises.
- WAIT_CYCLES=0 and 15: write pulse width = 1 and 16 cycles; read capture occurs on the last sram_oe_n=0 cycle.
- Both strobes low in the same cycle, data 0x5A -> write of 0x5A performed, collision=1 for 1 cycle, no read; with SRAM_BRIDGE_DEBUG_EN, debug[7:6]=1.
- Reset=0 asserted during WR_PULSE -> same instant: sram_we_n=1, sram_data=Z, busy=0; after release, next write behaves normally.
- Contention checker over random back-to-back reads/writes -> never sram_oe_n=0 with sram_data driven; never avr_data driven outside RD_DRIVE.
